// File: rtl/apb_pkg.sv
// ============================================================================
// Module  : apb_pkg
// Brief   : Shared types and constants for the arbitrating APB master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic psel;
        logic penable;
    } apb_phase_t;

    localparam apb_phase_t c_phase_idle   = '{psel: 1'b0, penable: 1'b0};
    localparam apb_phase_t c_phase_setup  = '{psel: 1'b1, penable: 1'b0};
    localparam apb_phase_t c_phase_access = '{psel: 1'b1, penable: 1'b1};

    // A disabled timeout still needs a one-bit counter to keep declarations legal.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
// ============================================================================
// Module  : apb_rr_arbiter
// Brief   : Combinational round-robin grant; scans from ptr+1 modulo NREQ.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any
);

    always_comb begin : p_scan
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_arb_master.sv
// ============================================================================
// Module  : apb_arb_master
// Brief   : Round-robin multi-requester APB master with timeout abort.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_arb_master
    import apb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  req_ready,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic [AW-1:0]    paddr,
    output logic             pwrite,
    output logic             psel,
    output logic             penable,
    output logic [DW-1:0]    pwdata,
    input  logic [DW-1:0]    prdata,
    input  logic             pready,
    input  logic             pslverr
);

    localparam int c_pw = $clog2(NREQ);
    localparam int c_cw = cnt_width(TIMEOUT);
    localparam logic [c_cw-1:0] c_cnt_sat  = '1;
    localparam logic [c_cw-1:0] c_cnt_last = (TIMEOUT > 0) ? c_cw'(TIMEOUT - 1) : '0;
    localparam logic [c_pw-1:0] c_ptr_rst  = c_pw'(NREQ - 1);

    apb_state_t      r_state, w_state_nxt;
    logic [c_pw-1:0] r_ptr, w_ptr_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [c_cw-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0]   r_paddr, w_paddr_nxt;
    logic            r_pwrite, w_pwrite_nxt;
    logic [DW-1:0]   r_pwdata, w_pwdata_nxt;
    apb_phase_t      r_phase, w_phase_nxt;
    logic [NREQ-1:0] r_req_ready, w_req_ready_nxt;
    logic [NREQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic            r_rsp_err, w_rsp_err_nxt;

    logic [NREQ-1:0] w_gnt;
    logic [c_pw-1:0] w_gnt_idx;
    logic            w_any;
    logic [AW-1:0]   w_win_addr;
    logic [DW-1:0]   w_win_wdata;
    logic            w_win_write;
    logic            w_to_hit;

    apb_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (c_pw)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_gnt),
        .grant_idx (w_gnt_idx),
        .any       (w_any)
    );

    assign w_win_addr  = req_addr[int'(w_gnt_idx)*AW +: AW];
    assign w_win_wdata = req_wdata[int'(w_gnt_idx)*DW +: DW];
    assign w_win_write = req_write[w_gnt_idx];
    // Counter was cleared in SETUP, so reaching TIMEOUT-1 here means this is the last allowed cycle.
    assign w_to_hit    = (TIMEOUT != 0) && (r_cnt == c_cnt_last);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (pready || w_to_hit) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = r_gnt;
        w_cnt_nxt       = r_cnt;
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_phase_nxt     = r_phase;
        w_req_ready_nxt = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = c_phase_idle;
                if (w_any) begin
                    w_paddr_nxt     = w_win_addr;
                    w_pwrite_nxt    = w_win_write;
                    w_pwdata_nxt    = w_win_wdata;
                    w_phase_nxt     = c_phase_setup;
                    w_req_ready_nxt = w_gnt;
                    w_gnt_nxt       = w_gnt;
                    w_ptr_nxt       = w_gnt_idx;
                end
            end
            ST_SETUP: begin
                w_phase_nxt = c_phase_access;
                w_cnt_nxt   = '0;
            end
            ST_ACCESS: begin
                if (pready) begin
                    w_rsp_valid_nxt = r_gnt;
                    w_rsp_err_nxt   = pslverr;
                    w_rsp_rdata_nxt = (!r_pwrite && !pslverr) ? prdata : '0;
                    w_phase_nxt     = c_phase_idle;
                end else if (w_to_hit) begin
                    w_rsp_valid_nxt = r_gnt;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_phase_nxt     = c_phase_idle;
                end else if (r_cnt != c_cnt_sat) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_phase_nxt = c_phase_idle;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_ptr       <= c_ptr_rst;
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_phase     <= c_phase_idle;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_phase     <= w_phase_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign psel      = r_phase.psel;
    assign penable   = r_phase.penable;

endmodule

`default_nettype wire
